// File: rtl/hazard_pkg.sv
// Shared types and parameter checks for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StLuStall = 2'd1,
      StFlush   = 2'd2
   } hz_state_t;

   localparam int unsigned CntBits = 3;

   function automatic bit lu_stall_ok(input int unsigned v);
      return (v >= 1) && (v <= 7);
   endfunction

   function automatic bit br_flush_ok(input int unsigned v);
      return (v >= 1) && (v <= 3);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / cache-freeze hazard controller with stall and flush counters.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned LU_STALL = 1,
   parameter int unsigned BR_FLUSH = 1,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             branch_taken,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   input  logic             perf_clr,
   output logic             stall_pc,
   output logic             stall_if_id,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             freeze,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   if (!lu_stall_ok(LU_STALL)) begin : g_bad_lu_stall
      $error("hazard_ctrl_unit: LU_STALL must be in 1..7");
   end
   if (!br_flush_ok(BR_FLUSH)) begin : g_bad_br_flush
      $error("hazard_ctrl_unit: BR_FLUSH must be in 1..3");
   end

   // cnt holds the cycles remaining after the current one, hence the -2.
   localparam logic [CntBits-1:0] LuInit = (LU_STALL > 1) ? CntBits'(LU_STALL - 2) : '0;
   localparam logic [CntBits-1:0] BrInit = (BR_FLUSH > 1) ? CntBits'(BR_FLUSH - 2) : '0;

   hz_state_t            state_q, state_d;
   logic [CntBits-1:0]   cnt_q, cnt_d;
   logic                 frz;
   logic                 lu_hit;

   assign frz    = icache_stall | dcache_stall;
   assign lu_hit = ex_memread && (ex_rd != '0) &&
                   ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Frozen cycles leave state and cnt untouched so the sequence resumes intact.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!frz) begin
         if (branch_taken) begin
            state_d = (BR_FLUSH > 1) ? StFlush : StRun;
            cnt_d   = BrInit;
         end else begin
            unique case (state_q)
               StRun: begin
                  if (lu_hit && (LU_STALL > 1)) begin
                     state_d = StLuStall;
                     cnt_d   = LuInit;
                  end
               end
               StLuStall, StFlush: begin
                  if (cnt_q == '0) begin
                     state_d = StRun;
                  end else begin
                     cnt_d = cnt_q - 1'b1;
                  end
               end
               default: begin
                  state_d = StRun;
                  cnt_d   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      stall_pc    = 1'b0;
      stall_if_id = 1'b0;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      freeze      = 1'b0;
      if (!rst) begin
         freeze = frz;
         if (!frz) begin
            if (branch_taken) begin
               flush_if_id = 1'b1;
               flush_id_ex = 1'b1;
            end else begin
               unique case (state_q)
                  StRun: begin
                     if (lu_hit) begin
                        stall_pc    = 1'b1;
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                     end
                  end
                  StLuStall: begin
                     stall_pc    = 1'b1;
                     stall_if_id = 1'b1;
                     flush_id_ex = 1'b1;
                  end
                  StFlush: begin
                     flush_if_id = 1'b1;
                     flush_id_ex = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (perf_clr),
      .inc   (stall_pc | freeze),
      .count (stall_cycles)
   );

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (perf_clr),
      .inc   (branch_taken & ~frz & ~rst),
      .count (flush_events)
   );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: two instances (LU=2/BR=3/32-bit and LU=3/BR=2/4-bit) share one stimulus.
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ex_rd, id_rs1, id_rs2;
   logic       ex_memread, id_rs1_used, id_rs2_used, branch_taken;
   logic       icache_stall, dcache_stall, perf_clr;

   logic        sp_a, sid_a, fid_a, fie_a, frz_a;
   logic [31:0] sc_a, fe_a;
   logic        sp_b, sid_b, fid_b, fie_b, frz_b;
   logic [3:0]  sc_b, fe_b;
   logic [4:0]  ctl_a, ctl_b;

   int checks = 0;
   int errors = 0;

   // {stall_pc, stall_if_id, flush_if_id, flush_id_ex, freeze}
   assign ctl_a = {sp_a, sid_a, fid_a, fie_a, frz_a};
   assign ctl_b = {sp_b, sid_b, fid_b, fie_b, frz_b};

   always #5 clk = ~clk;

   hazard_ctrl_unit #(
      .REG_W (5), .LU_STALL (2), .BR_FLUSH (3), .CNT_W (32)
   ) dut_a (
      .clk (clk), .rst (rst), .ex_rd (ex_rd), .ex_memread (ex_memread),
      .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used), .branch_taken (branch_taken),
      .icache_stall (icache_stall), .dcache_stall (dcache_stall), .perf_clr (perf_clr),
      .stall_pc (sp_a), .stall_if_id (sid_a), .flush_if_id (fid_a), .flush_id_ex (fie_a),
      .freeze (frz_a), .stall_cycles (sc_a), .flush_events (fe_a)
   );

   hazard_ctrl_unit #(
      .REG_W (5), .LU_STALL (3), .BR_FLUSH (2), .CNT_W (4)
   ) dut_b (
      .clk (clk), .rst (rst), .ex_rd (ex_rd), .ex_memread (ex_memread),
      .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_rs1_used (id_rs1_used),
      .id_rs2_used (id_rs2_used), .branch_taken (branch_taken),
      .icache_stall (icache_stall), .dcache_stall (dcache_stall), .perf_clr (perf_clr),
      .stall_pc (sp_b), .stall_if_id (sid_b), .flush_if_id (fid_b), .flush_id_ex (fie_b),
      .freeze (frz_b), .stall_cycles (sc_b), .flush_events (fe_b)
   );

   task automatic clear_inputs();
      ex_rd = '0; id_rs1 = '0; id_rs2 = '0;
      ex_memread = 0; id_rs1_used = 0; id_rs2_used = 0; branch_taken = 0;
      icache_stall = 0; dcache_stall = 0; perf_clr = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic set_hit();
      ex_memread = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1;
      id_rs1 = 5'd3; id_rs1_used = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      set_hit();
      branch_taken = 1;
      dcache_stall = 1;
      #1;
      checks++;
      if (ctl_a !== 5'b00000 || ctl_b !== 5'b00000) begin
         $display("FAIL reset_outputs: got a=%b b=%b expected 00000", ctl_a, ctl_b);
         errors++;
      end
      next_cycle();
      checks++;
      if (sc_a !== 32'd0 || fe_a !== 32'd0 || sc_b !== 4'd0 || fe_b !== 4'd0) begin
         $display("FAIL reset_counters: got %0d %0d %0d %0d expected 0", sc_a, fe_a, sc_b, fe_b);
         errors++;
      end
      clear_inputs();
      rst = 1'b0;
      #4;
      checks++;
      if (ctl_a !== 5'b00000 || ctl_b !== 5'b00000) begin
         $display("FAIL reset_release: got a=%b b=%b expected 00000", ctl_a, ctl_b);
         errors++;
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_hit();
      #4;
      checks++;
      if (ctl_a !== 5'b11010) begin
         $display("FAIL lu_cycle1: got %b expected 11010", ctl_a);
         errors++;
      end
      next_cycle();
      clear_inputs();
      #4;
      checks++;
      if (ctl_a !== 5'b11010 || sc_a !== 32'd1) begin
         $display("FAIL lu_cycle2: got ctl=%b sc=%0d expected 11010 sc=1", ctl_a, sc_a);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_a !== 5'b00000 || sc_a !== 32'd2) begin
         $display("FAIL lu_end: got ctl=%b sc=%0d expected 00000 sc=2", ctl_a, sc_a);
         errors++;
      end
      checks++;
      if (ctl_b !== 5'b11010) begin
         $display("FAIL lu3_cycle3: got %b expected 11010", ctl_b);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_b !== 5'b00000 || sc_b !== 4'd3) begin
         $display("FAIL lu3_end: got ctl=%b sc=%0d expected 00000 sc=3", ctl_b, sc_b);
         errors++;
      end
   endtask

   task automatic test_x0_unused();
      do_reset();
      ex_memread = 1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1;
      #4;
      checks++;
      if (ctl_a !== 5'b00000 || ctl_b !== 5'b00000) begin
         $display("FAIL x0_no_stall: got a=%b b=%b expected 00000", ctl_a, ctl_b);
         errors++;
      end
      next_cycle();
      ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 0; id_rs2 = 5'd3; id_rs2_used = 1;
      #4;
      checks++;
      if (ctl_a !== 5'b00000) begin
         $display("FAIL unused_rs1_no_stall: got %b expected 00000", ctl_a);
         errors++;
      end
      next_cycle();
      ex_memread = 0; id_rs1_used = 1;
      #4;
      checks++;
      if (ctl_a !== 5'b00000) begin
         $display("FAIL not_load_no_stall: got %b expected 00000", ctl_a);
         errors++;
      end
      next_cycle();
      ex_memread = 1;
      #4;
      checks++;
      if (ctl_a !== 5'b11010 || sc_a !== 32'd0) begin
         $display("FAIL rs1_match_stall: got ctl=%b sc=%0d expected 11010 sc=0", ctl_a, sc_a);
         errors++;
      end
   endtask

   task automatic test_branch_in_stall();
      do_reset();
      set_hit();
      #4;
      checks++;
      if (ctl_b !== 5'b11010) begin
         $display("FAIL bis_stall1: got %b expected 11010", ctl_b);
         errors++;
      end
      next_cycle();
      clear_inputs();
      branch_taken = 1;
      #4;
      checks++;
      if (ctl_b !== 5'b00110) begin
         $display("FAIL bis_abort: got %b expected 00110", ctl_b);
         errors++;
      end
      next_cycle();
      branch_taken = 0;
      #4;
      checks++;
      if (ctl_b !== 5'b00110 || fe_b !== 4'd1) begin
         $display("FAIL bis_flush2: got ctl=%b fe=%0d expected 00110 fe=1", ctl_b, fe_b);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_b !== 5'b00000 || fe_b !== 4'd1 || sc_b !== 4'd1) begin
         $display("FAIL bis_end: got ctl=%b fe=%0d sc=%0d expected 00000 fe=1 sc=1",
                  ctl_b, fe_b, sc_b);
         errors++;
      end
   endtask

   task automatic test_freeze_mid_flush();
      do_reset();
      branch_taken = 1;
      #4;
      checks++;
      if (ctl_a !== 5'b00110 || ctl_b !== 5'b00110) begin
         $display("FAIL fz_branch: got a=%b b=%b expected 00110", ctl_a, ctl_b);
         errors++;
      end
      next_cycle();
      branch_taken = 0;
      dcache_stall = 1;
      for (int i = 0; i < 4; i++) begin
         #4;
         checks++;
         if (ctl_a !== 5'b00001 || ctl_b !== 5'b00001) begin
            $display("FAIL fz_frozen%0d: got a=%b b=%b expected 00001", i, ctl_a, ctl_b);
            errors++;
         end
         next_cycle();
      end
      dcache_stall = 0;
      #4;
      checks++;
      if (ctl_a !== 5'b00110 || ctl_b !== 5'b00110 || sc_a !== 32'd4 || sc_b !== 4'd4) begin
         $display("FAIL fz_resume: got a=%b b=%b sca=%0d scb=%0d expected 00110 sc=4",
                  ctl_a, ctl_b, sc_a, sc_b);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_b !== 5'b00000 || ctl_a !== 5'b00110) begin
         $display("FAIL fz_tail: got a=%b b=%b expected a=00110 b=00000", ctl_a, ctl_b);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_a !== 5'b00000 || fe_a !== 32'd1) begin
         $display("FAIL fz_done: got ctl=%b fe=%0d expected 00000 fe=1", ctl_a, fe_a);
         errors++;
      end
   endtask

   task automatic test_flush_restart();
      do_reset();
      branch_taken = 1;
      next_cycle();
      #4;
      checks++;
      if (ctl_a !== 5'b00110) begin
         $display("FAIL fr_restart: got %b expected 00110", ctl_a);
         errors++;
      end
      next_cycle();
      branch_taken = 0;
      for (int i = 0; i < 2; i++) begin
         #4;
         checks++;
         if (ctl_a !== 5'b00110) begin
            $display("FAIL fr_flush%0d: got %b expected 00110", i, ctl_a);
            errors++;
         end
         next_cycle();
      end
      #4;
      checks++;
      if (ctl_a !== 5'b00000 || fe_a !== 32'd2) begin
         $display("FAIL fr_end: got ctl=%b fe=%0d expected 00000 fe=2", ctl_a, fe_a);
         errors++;
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_hit();
      next_cycle();
      clear_inputs();
      #2;
      checks++;
      if (ctl_b !== 5'b11010 || sc_b !== 4'd1) begin
         $display("FAIL ar_pre: got ctl=%b sc=%0d expected 11010 sc=1", ctl_b, sc_b);
         errors++;
      end
      rst = 1'b1;
      #1;
      checks++;
      if (ctl_b !== 5'b00000 || sc_b !== 4'd0 || sc_a !== 32'd0) begin
         $display("FAIL ar_immediate: got ctl=%b scb=%0d sca=%0d expected 00000 0 0",
                  ctl_b, sc_b, sc_a);
         errors++;
      end
      next_cycle();
      rst = 1'b0;
      #4;
      checks++;
      if (ctl_b !== 5'b00000 || ctl_a !== 5'b00000) begin
         $display("FAIL ar_release: got a=%b b=%b expected 00000", ctl_a, ctl_b);
         errors++;
      end
      next_cycle();
      #4;
      checks++;
      if (ctl_b !== 5'b00000 || sc_b !== 4'd0) begin
         $display("FAIL ar_no_residual: got ctl=%b sc=%0d expected 00000 sc=0", ctl_b, sc_b);
         errors++;
      end
   endtask

   task automatic test_saturation();
      do_reset();
      icache_stall = 1;
      repeat (20) next_cycle();
      #4;
      checks++;
      if (sc_b !== 4'd15 || sc_a !== 32'd20 || ctl_b !== 5'b00001) begin
         $display("FAIL sat_hold: got scb=%0d sca=%0d ctl=%b expected 15 20 00001",
                  sc_b, sc_a, ctl_b);
         errors++;
      end
      next_cycle();
      icache_stall = 0;
      perf_clr = 1;
      next_cycle();
      perf_clr = 0;
      #4;
      checks++;
      if (sc_b !== 4'd0 || sc_a !== 32'd0) begin
         $display("FAIL sat_clear: got scb=%0d sca=%0d expected 0 0", sc_b, sc_a);
         errors++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load_use();
      test_x0_unused();
      test_branch_in_stall();
      test_freeze_mid_flush();
      test_flush_restart();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
